ps2_receive: RTL

//  Device-to-host PS/2 receiver; downstream stage of PS2_send on the same PS2C/PS2D lines.

---
 rtl/ps2_pkg.sv | 23 ++
 rtl/ps2_line_filter.sv | 51 +++++
 rtl/ps2_receive.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: status codes, FSM encoding, frame constants.
package ps2_pkg;

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_RECV    = 4'd1;
  localparam logic [3:0] ST_OK      = 4'd2;
  localparam logic [3:0] ST_PARITY  = 4'd3;
  localparam logic [3:0] ST_FRAMING = 4'd4;
  localparam logic [3:0] ST_TIMEOUT = 4'd5;

  // Start, eight data bits LSB first, odd parity, stop.
  localparam int FRAME_LEN = 11;

  localparam logic [7:0] BYTE_ACK      = 8'hFA;
  localparam logic [7:0] BYTE_SELFTEST = 8'hAA;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_CHECK = 2'd2
  } rx_state_t;

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 clock line conditioner: 2-FF synchroniser, FILTER_LEN-sample debounce,
// and a 1-cycle pulse when the debounced level goes 1 -> 0.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic          sync_p0;
  logic          sync_p1;
  logic          level;
  logic [CW-1:0] cnt;

  // Two-flop synchroniser; the line idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= line;
      sync_p1 <= sync_p0;
    end
  end

  // Accept a new level only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= 1'b1;
      cnt   <= '0;
      fall  <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_p1;
        cnt   <= '0;
        fall  <= level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_receive.sv
// Device-to-host PS/2 receiver: deframes 11-bit frames sampled in the qzt_clk
// domain and emits one byte with a valid strobe, or an err strobe with a cause.
// Optional inter-edge watchdog enabled by defining PS2_RX_TIMEOUT_EN.
module ps2_receive
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       qzt_clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       PS2C,
  input  logic       PS2D,
  output logic [7:0] data,
  output logic       valid,
  output logic       err,
  output logic [3:0] status
);

`ifdef PS2_RX_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam logic [16:0] TO_LAST  = 17'(TIMEOUT_CYC - 1);
  localparam logic [3:0]  BIT_LAST = 4'(FRAME_LEN - 1);

  logic        fall;
  logic        ps2d_p0;
  logic        ps2d_p1;

  rx_state_t   state,   state_nxt;
  logic [3:0]  bit_cnt, bit_cnt_nxt;
  logic [10:0] sr,      sr_nxt;
  logic [16:0] wd,      wd_nxt;
  logic [7:0]  data_nxt;
  logic [3:0]  status_nxt;
  logic        valid_nxt;
  logic        err_nxt;
  logic [10:0] frame_w;

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_filter (
    .clk (qzt_clk),
    .rst (reset),
    .line(PS2C),
    .fall(fall)
  );

  // PS2D only needs synchronising: it is sampled mid-low of a debounced clock.
  always_ff @(posedge qzt_clk) begin
    if (reset) begin
      ps2d_p0 <= 1'b1;
      ps2d_p1 <= 1'b1;
    end else begin
      ps2d_p0 <= PS2D;
      ps2d_p1 <= ps2d_p0;
    end
  end

  // Frame as it will look once the current data bit is shifted in.
  assign frame_w = {ps2d_p1, sr[10:1]};

  // State, shift register, watchdog and registered outputs.
  always_ff @(posedge qzt_clk) begin
    if (reset) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      sr      <= '0;
      wd      <= '0;
      data    <= 8'h00;
      valid   <= 1'b0;
      err     <= 1'b0;
      status  <= ST_IDLE;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      sr      <= sr_nxt;
      wd      <= wd_nxt;
      data    <= data_nxt;
      valid   <= valid_nxt;
      err     <= err_nxt;
      status  <= status_nxt;
    end
  end

  // Next-state logic; the frame is judged on its 11th edge so the strobe
  // lands in the single CHECK cycle that follows.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    sr_nxt      = sr;
    wd_nxt      = wd;
    data_nxt    = data;
    status_nxt  = status;
    valid_nxt   = 1'b0;
    err_nxt     = 1'b0;

    if (!enable) begin
      // Disabling wins over a coincident edge; status is left as it was.
      state_nxt   = S_IDLE;
      bit_cnt_nxt = '0;
      wd_nxt      = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (fall) begin
            state_nxt   = S_RECV;
            sr_nxt      = {ps2d_p1, 10'b0};
            bit_cnt_nxt = 4'd1;
            wd_nxt      = '0;
            status_nxt  = ST_RECV;
          end
        end
        S_RECV: begin
          if (fall) begin
            sr_nxt      = frame_w;
            bit_cnt_nxt = bit_cnt + 4'd1;
            wd_nxt      = '0;
            if (bit_cnt == BIT_LAST) begin
              state_nxt   = S_CHECK;
              bit_cnt_nxt = '0;
              if (frame_w[0] || !frame_w[10]) begin
                err_nxt    = 1'b1;
                status_nxt = ST_FRAMING;
              end else if (!(^frame_w[9:1])) begin
                err_nxt    = 1'b1;
                status_nxt = ST_PARITY;
              end else begin
                valid_nxt  = 1'b1;
                data_nxt   = frame_w[8:1];
                status_nxt = ST_OK;
              end
            end
          end else if (TO_EN && wd == TO_LAST) begin
            state_nxt   = S_IDLE;
            bit_cnt_nxt = '0;
            wd_nxt      = '0;
            err_nxt     = 1'b1;
            status_nxt  = ST_TIMEOUT;
          end else if (TO_EN) begin
            wd_nxt = wd + 17'd1;
          end
        end
        S_CHECK: begin
          state_nxt = S_IDLE;
        end
        default: begin
          state_nxt   = S_IDLE;
          bit_cnt_nxt = '0;
        end
      endcase
    end
  end

endmodule
